jtag_reg_bank: RTL and testbench
================================

JTAG_REG_BANK -- requirements
Module: jtag_reg_bank

Interface
REQ-001 SHALL have port tck, input, 1, sole clock; all flops on rising edge.
REQ-002 SHALL have port trst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port tdi, input, 1, serial data from pin.
REQ-004 SHALL have port shift_dr, input, 1, TAP Shift-DR state flag.
REQ-005 SHALL have port sync_capture_en, input, 1, single-cycle capture enable from TAP.
REQ-006 SHALL have port sync_update_dr, input, 1, single-cycle update enable from TAP.
REQ-007 SHALL have port instructions, input, 5, current TAP instruction.
REQ-008 SHALL have port stat_in, input, 16, read-only status word.
REQ-009 SHALL have port so, output, 1, serial data to TAP.
REQ-010 SHALL have port bypass_sel, output, 1, high when instruction is not owned here.
REQ-011 SHALL have port cfg_out, output, 240, registers 0..14 flattened; reg n at bits [16n+15:16n].
REQ-012 SHALL have port err, output, 1, sticky out-of-range access flag.

Function
REQ-013 SHALL decode instructions: 5'h08 = ADDR (8-bit address shift register), 5'h09 = DATA (16-bit data shift register), 5'h0A = ERRCLR (1-bit DR); any other code SHALL drive bypass_sel=1 and leave all state untouched.
REQ-014 SHALL shift LSB first: on shift_dr with owned instruction, selected SR <= {tdi, SR[W-1:1]}; so = selected SR[0] combinationally; so=0 when bypass_sel=1.
REQ-015 SHALL, on sync_capture_en: ADDR SR <= current addr; DATA SR <= reg[addr] for addr 0..14, stat_in for addr 15, 16'hDEAD for addr >= 16; ERRCLR SR <= err.
REQ-016 SHALL give capture priority over shift if both asserted in the same cycle.
REQ-017 SHALL, on sync_update_dr: ADDR -> addr <= ADDR SR; DATA -> reg[addr] <= DATA SR if addr <= 14; ERRCLR -> err <= 0 if ERRCLR SR[0] = 1.
REQ-018 SHALL set err on a DATA update with addr >= 15 (write to read-only or out of range), with no register change; a set on the same cycle as a clear SHALL win.
REQ-019 SHALL update cfg_out one cycle after sync_update_dr (registered outputs, no combinational path from tdi).
REQ-020 SHALL keep a separate SR per instruction; changing instruction SHALL not corrupt the other SRs or addr.

Reset
REQ-021 SHALL, on trst=1 at a tck edge, clear addr, all SRs, all registers (cfg_out=0), and err; bypass_sel and so follow decode of instructions.
REQ-022 SHALL let reset override capture, shift, and update in the same cycle, including mid-shift.

Configuration
REQ-023 SHALL honour macro JTAG_REG_BANK_AUTOINC_EN: when defined, every DATA update (write attempted or rejected) SHALL increment addr modulo 256 in the same cycle; when undefined, addr SHALL change only on ADDR update.
REQ-024 SHALL treat the auto-increment wrap (addr 8'hFF -> 8'h00) as normal, with no err.

Verification
REQ-025 Reset, then capture/shift DATA at addr 0 -> 16'h0000 shifted out, err=0, cfg_out=0.
REQ-026 ADDR update 8'h03, DATA update 16'hA5C3 -> cfg_out[63:48]=16'hA5C3 one cycle later; recapture returns A5C3 LSB first.
REQ-027 ADDR 8'h0F, stat_in=16'h1234, capture DATA -> shifts out 1234; write 16'hFFFF -> register file unchanged, err=1; ERRCLR update with 1 -> err=0.
REQ-028 ADDR 8'h20, capture DATA -> 16'hDEAD; instruction 5'h1F -> bypass_sel=1, so=0, state held.
REQ-029 With JTAG_REG_BANK_AUTOINC_EN: ADDR 8'h0E, two DATA writes 1111 and 2222 -> reg14=1111, second write rejected, err=1, addr=8'h10; without the macro, both writes hit reg14 (final 2222).
REQ-030 Assert trst during the 9th shift bit of a DATA scan -> all registers and err cleared; next capture returns 0.

Source files
------------

// File: rtl/jtag_reg_bank_if.sv
// jtag_reg_bank_if: TAP-side data-register signals shared by the TAP controller (master) and the register bank (slave).
interface jtag_reg_bank_if;
    logic       tdi;
    logic       shift_dr;
    logic       sync_capture_en;
    logic       sync_update_dr;
    logic [4:0] instructions;
    logic       so;
    logic       bypass_sel;
    modport master (
        output tdi, shift_dr, sync_capture_en, sync_update_dr, instructions,
        input  so, bypass_sel
    );
    modport slave (
        input  tdi, shift_dr, sync_capture_en, sync_update_dr, instructions,
        output so, bypass_sel
    );
endinterface

// File: rtl/jtag_reg_bank.sv
// jtag_reg_bank: JTAG-accessible bank of 15 config registers plus a status word and a sticky error flag.
// Optional JTAG_REG_BANK_AUTOINC_EN: every DATA update post-increments the address.
module jtag_reg_bank (
    input  logic                tck,
    input  logic                trst,
    jtag_reg_bank_if.slave      bus,
    input  logic [15:0]         stat_in,
    output logic [239:0]        cfg_out,
    output logic                err
);
    localparam logic [4:0] INS_ADDR  = 5'h08;
    localparam logic [4:0] INS_DATA  = 5'h09;
    localparam logic [4:0] INS_ERRCLR = 5'h0A;
    logic [7:0]  r_addr;
    logic [7:0]  r_asr;
    logic [15:0] r_dsr;
    logic        r_esr;
    logic        r_err;
    logic [15:0] r_regs [15];
    logic        w_is_a;
    logic        w_is_d;
    logic        w_is_e;
    logic        w_wr_ok;
    logic [15:0] w_cap_data;
    assign w_is_a  = bus.instructions == INS_ADDR;
    assign w_is_d  = bus.instructions == INS_DATA;
    assign w_is_e  = bus.instructions == INS_ERRCLR;
    assign w_wr_ok = r_addr < 8'd15;
    assign w_cap_data = w_wr_ok ? r_regs[r_addr[3:0]] : r_addr == 8'd15 ? stat_in : 16'hDEAD;
    assign bus.bypass_sel = !(w_is_a || w_is_d || w_is_e);
    assign bus.so = w_is_a ? r_asr[0] : w_is_d ? r_dsr[0] : w_is_e ? r_esr : 1'b0;
    assign err = r_err;
    for (genvar n = 0; n < 15; n++) begin : g_cfg
        assign cfg_out[16*n +: 16] = r_regs[n];
    end
    always_ff @(posedge tck) begin
        if (trst) begin
            r_addr <= '0;
            r_asr  <= '0;
            r_dsr  <= '0;
            r_esr  <= 1'b0;
            r_err  <= 1'b0;
            for (int i = 0; i < 15; i++) r_regs[i] <= '0;
        end else begin
            if (bus.sync_capture_en) begin
                if (w_is_a) r_asr <= r_addr;
                if (w_is_d) r_dsr <= w_cap_data;
                if (w_is_e) r_esr <= r_err;
            end else if (bus.shift_dr) begin
                if (w_is_a) r_asr <= {bus.tdi, r_asr[7:1]};
                if (w_is_d) r_dsr <= {bus.tdi, r_dsr[15:1]};
                if (w_is_e) r_esr <= bus.tdi;
            end
            if (bus.sync_update_dr) begin
                if (w_is_a) r_addr <= r_asr;
                if (w_is_d) begin
                    if (w_wr_ok) r_regs[r_addr[3:0]] <= r_dsr;
`ifdef JTAG_REG_BANK_AUTOINC_EN
                    r_addr <= r_addr + 8'd1;
`endif
                end
                // a rejected write setting err takes precedence over a clear
                if (w_is_d && !w_wr_ok) r_err <= 1'b1;
                else if (w_is_e && r_esr) r_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jtag_reg_bank.sv
// tb_jtag_reg_bank: directed scans with a queue of expected shift-out words and state checks.
module tb_jtag_reg_bank;
    logic         tck = 1'b0;
    logic         trst = 1'b1;
    logic [15:0]  stat_in = 16'h0;
    logic [239:0] cfg_out;
    logic         err;
    logic [239:0] exp_cfg = '0;
    logic [15:0]  sout;
    logic [15:0]  exp_q [$];
    int           n_err = 0;
    int           n_chk = 0;
    jtag_reg_bank_if bus ();
    jtag_reg_bank dut (.tck(tck), .trst(trst), .bus(bus.slave), .stat_in(stat_in), .cfg_out(cfg_out), .err(err));
    always #5 tck = ~tck;
`ifdef JTAG_REG_BANK_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif
    task automatic check(input string tag, input logic [239:0] obs, input logic [239:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic scan(input logic [4:0] ins, input int w, input logic [15:0] din, input bit upd, input bit both);
        sout = '0;
        @(negedge tck);
        bus.instructions = ins;
        bus.sync_capture_en = 1'b1;
        bus.shift_dr = both;
        @(negedge tck);
        bus.sync_capture_en = 1'b0;
        bus.shift_dr = 1'b1;
        for (int i = 0; i < w; i++) begin
            sout[i] = bus.so;
            bus.tdi = din[i];
            @(negedge tck);
        end
        bus.shift_dr = 1'b0;
        bus.sync_update_dr = upd;
        @(negedge tck);
        bus.sync_update_dr = 1'b0;
    endtask
    task automatic scan_chk(input string tag, input logic [4:0] ins, input int w, input logic [15:0] din,
                            input bit upd, input bit both, input logic [15:0] exp);
        exp_q.push_back(exp);
        scan(ins, w, din, upd, both);
        if (exp_q.size() == 0) check({tag, "_queue"}, 1, 0);
        else check(tag, {224'b0, sout}, {224'b0, exp_q.pop_front()});
    endtask
    initial begin
        bus.tdi = 1'b0;
        bus.shift_dr = 1'b0;
        bus.sync_capture_en = 1'b0;
        bus.sync_update_dr = 1'b0;
        bus.instructions = 5'h08;
        repeat (2) @(negedge tck);
        trst = 1'b0;
        check("rst_cfg", cfg_out, '0);
        check("rst_err", {239'b0, err}, '0);
        check("rst_bypass", {239'b0, bus.bypass_sel}, '0);
        check("rst_so", {239'b0, bus.so}, '0);
        scan_chk("data0", 5'h09, 16, 16'h0, 1'b0, 1'b0, 16'h0000);
        check("data0_err", {239'b0, err}, '0);
        check("data0_cfg", cfg_out, '0);
        scan_chk("addr3", 5'h08, 8, 16'h03, 1'b1, 1'b0, 16'h0000);
        scan_chk("wr_a5c3", 5'h09, 16, 16'hA5C3, 1'b1, 1'b0, 16'h0000);
        exp_cfg[63:48] = 16'hA5C3;
        check("cfg_reg3", cfg_out, exp_cfg);
        scan_chk("addr3_again", 5'h08, 8, 16'h03, 1'b1, 1'b1, AI ? 16'h04 : 16'h03);
        scan_chk("recap_a5c3", 5'h09, 16, 16'h0, 1'b0, 1'b1, 16'hA5C3);
        scan_chk("addr_f", 5'h08, 8, 16'h0F, 1'b1, 1'b0, 16'h03);
        stat_in = 16'h1234;
        scan_chk("stat_cap", 5'h09, 16, 16'h0, 1'b0, 1'b0, 16'h1234);
        scan_chk("wr_ro", 5'h09, 16, 16'hFFFF, 1'b1, 1'b0, 16'h1234);
        check("ro_cfg", cfg_out, exp_cfg);
        check("ro_err", {239'b0, err}, 240'd1);
        scan_chk("errclr0", 5'h0A, 1, 16'h0, 1'b1, 1'b0, 16'h1);
        check("errclr0_err", {239'b0, err}, 240'd1);
        scan_chk("errclr1", 5'h0A, 1, 16'h1, 1'b1, 1'b0, 16'h1);
        check("errclr1_err", {239'b0, err}, '0);
        scan_chk("addr20", 5'h08, 8, 16'h20, 1'b1, 1'b0, AI ? 16'h10 : 16'h0F);
        scan_chk("dead_cap", 5'h09, 16, 16'h0, 1'b0, 1'b0, 16'hDEAD);
        @(negedge tck);
        bus.instructions = 5'h1F;
        bus.tdi = 1'b1;
        @(negedge tck);
        check("byp_sel", {239'b0, bus.bypass_sel}, 240'd1);
        check("byp_so", {239'b0, bus.so}, '0);
        bus.sync_capture_en = 1'b1;
        @(negedge tck);
        bus.sync_capture_en = 1'b0;
        bus.shift_dr = 1'b1;
        repeat (3) @(negedge tck);
        bus.shift_dr = 1'b0;
        bus.sync_update_dr = 1'b1;
        @(negedge tck);
        bus.sync_update_dr = 1'b0;
        check("byp_cfg", cfg_out, exp_cfg);
        check("byp_err", {239'b0, err}, '0);
        scan_chk("byp_addr_held", 5'h08, 8, 16'h0, 1'b0, 1'b0, 16'h20);
        scan_chk("addr_e", 5'h08, 8, 16'h0E, 1'b1, 1'b0, 16'h20);
        scan_chk("wr_1111", 5'h09, 16, 16'h1111, 1'b1, 1'b0, 16'h0000);
        scan_chk("wr_2222", 5'h09, 16, 16'h2222, 1'b1, 1'b0, AI ? 16'h1234 : 16'h1111);
        exp_cfg[239:224] = AI ? 16'h1111 : 16'h2222;
        check("reg14", cfg_out, exp_cfg);
        check("inc_err", {239'b0, err}, AI ? 240'd1 : 240'd0);
        scan_chk("inc_addr", 5'h08, 8, 16'h0F, 1'b1, 1'b0, AI ? 16'h10 : 16'h0E);
        scan_chk("wr_ro2", 5'h09, 16, 16'h5555, 1'b1, 1'b0, 16'h1234);
        check("ro2_err", {239'b0, err}, 240'd1);
        scan_chk("addr3_pre", 5'h08, 8, 16'h03, 1'b1, 1'b0, AI ? 16'h10 : 16'h0F);
        @(negedge tck);
        bus.instructions = 5'h09;
        bus.sync_capture_en = 1'b1;
        @(negedge tck);
        bus.sync_capture_en = 1'b0;
        bus.shift_dr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.tdi = 1'b1;
            @(negedge tck);
        end
        trst = 1'b1;
        @(negedge tck);
        trst = 1'b0;
        bus.shift_dr = 1'b0;
        check("midrst_cfg", cfg_out, '0);
        check("midrst_err", {239'b0, err}, '0);
        scan_chk("midrst_addr", 5'h08, 8, 16'h0, 1'b0, 1'b0, 16'h00);
        scan_chk("midrst_data", 5'h09, 16, 16'h0, 1'b0, 1'b0, 16'h0000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
